if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the hazard/forwarding unit's IF/ID consumers.
- Owns the PC register, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID pipeline register.
- Obeys PC_Enable / IF_ID_Pipeline_Enable from the hazard unit (load-use stall) and Branch_Taken / Branch_Target from ID (redirect + flush).
- Produces IF_ID_Instr, whose [25:21]/[20:16] fields become IF_ID_Reg_Rs/IF_ID_Reg_Rt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PC_Enable  in  1  hazard unit: 1 = PC may advance.
- IF_ID_Pipeline_Enable  in  1  hazard unit: 1 = IF/ID may load.
- Branch_Taken  in  1  ID stage: redirect fetch and flush IF/ID, single-cycle pulse.
- Branch_Target  in  32  redirect address; bits [1:0] ignored, forced to 0.
- imem_addr  out  32  word-aligned fetch address.
- imem_req  out  1  fetch request; held until imem_ready.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  response strobe; 0..N wait states.
- IF_ID_Instr  out  32  registered instruction.
- IF_ID_PC_Plus4  out  32  registered fetch PC + 4.
- IF_ID_Valid  out  1  1 = IF_ID_Instr is a real fetched instruction.

Behaviour:
- Reset (asynchronous, any state):
  - PC=RESET_PC, state=S_IDLE, imem_req=0.
  - IF_ID_Instr=NOP_INSTR, IF_ID_PC_Plus4=0, IF_ID_Valid=0, hold buffer empty.
- advance = PC_Enable & IF_ID_Pipeline_Enable. If the two disagree, treat as stall: PC and IF/ID both hold.
- Priority each cycle: reset > Branch_Taken > stall > advance.
- imem_addr = PC at all times. imem_req is combinational from state: 1 in S_FETCH and S_KILL, else 0.
- States:
  - S_IDLE: first cycle after reset release. No request. Go to S_FETCH.
  - S_FETCH, imem_ready=0: stay.
  - S_FETCH, imem_ready=1, advance: IF_ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4; stay. Back-to-back 1 instr/cycle with zero wait states.
  - S_FETCH, imem_ready=1, stall: capture {imem_rdata, PC+4} into hold buffer; IF/ID and PC unchanged; go to S_HOLD.
  - S_HOLD: imem_req=0. On advance: IF_ID <= hold buffer, valid=1; PC <= PC+4; go to S_FETCH.
  - Branch_Taken in S_FETCH with imem_ready=0: go to S_KILL.
  - S_KILL: wait for imem_ready; discard imem_rdata; go to S_FETCH. PC already holds the target.
- Branch_Taken in any state:
  - PC <= {Branch_Target[31:2],2'b00}.
  - IF_ID <= {NOP_INSTR, 0, valid=0}; hold buffer cleared.
  - Next state: S_KILL if a request is outstanding without ready, else S_FETCH.
  - A response arriving in the same cycle as Branch_Taken is discarded.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No exception.
- Stall during S_FETCH with no response: the request stays asserted; the response is buffered when it arrives.

Optional Feature:
- Macro: IF_STALL_COUNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and fetch_count[31:0].
  - stall_cycles increments each cycle advance=0 outside S_IDLE.
  - fetch_count increments on each IF/ID load with valid=1.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package if_pkg:
  - State enum {S_IDLE, S_FETCH, S_HOLD, S_KILL}, 2-bit encoding.
  - NOP_INSTR default.
  - Instruction field constants RS_MSB=25, RS_LSB=21, RT_MSB=20, RT_LSB=16.
- One sub-module: if_hold_buffer, a one-entry register {instr, pc_plus4, full} with load/clear/async reset.
- PC logic and FSM stay in the top.

Test Plan:
- Reset, then zero-wait memory returning addr as data for 4 cycles -> IF_ID_PC_Plus4 = 4, 8, 12, 16 on consecutive cycles; IF_ID_Valid=1 from the second fetch cycle.
- imem_ready delayed 3 cycles at PC=0x10 -> imem_req held with imem_addr=0x10 for 4 cycles; IF_ID unchanged until ready; PC then 0x14.
- Enables low for 2 cycles while the response for PC=0x20 arrives -> S_HOLD, imem_req=0, PC stays 0x20; on release IF_ID_Instr = buffered word, IF_ID_PC_Plus4=0x24.
- Branch_Taken with Branch_Target=0x103 during a 2-cycle wait -> next imem_addr=0x100, IF_ID_Valid=0 with NOP; the stale response is discarded; next valid IF_ID_PC_Plus4=0x104.
- RESET_PC=32'hFFFF_FFFC, one fetch -> IF_ID_PC_Plus4=0, PC=0.
- Assert reset mid-S_HOLD -> all outputs at reset values immediately (asynchronous), state S_IDLE, first request one cycle after release.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_KILL  = 2'd3
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// rtl/if_hold_buffer.sv - one-entry buffer parking a fetched word while IF/ID is stalled
module if_hold_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr    <= 32'h0;
            pc_plus4 <= 32'h0;
            full     <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            full     <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC, imem handshake and IF/ID register; IF_STALL_COUNT_EN adds stall/fetch counters
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Enable,
    input  logic        IF_ID_Pipeline_Enable,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic        IF_ID_Valid
`ifdef IF_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] fetch_count
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         advance;
    logic         fetch_load;
    logic         hold_unload;
    logic         hb_load;
    logic         hb_clear;
    logic [31:0]  hb_instr;
    logic [31:0]  hb_pc_plus4;
    logic         hb_full;

    // Disagreeing enables stall both PC and IF/ID so they stay in step.
    assign advance     = PC_Enable & IF_ID_Pipeline_Enable;
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign imem_req    = (state == S_FETCH) || (state == S_KILL);

    assign fetch_load  = !Branch_Taken && (state == S_FETCH) && imem_ready && advance;
    assign hold_unload = !Branch_Taken && (state == S_HOLD) && advance && hb_full;
    assign hb_load     = !Branch_Taken && (state == S_FETCH) && imem_ready && !advance;
    assign hb_clear    = Branch_Taken || hold_unload;

    if_hold_buffer u_hold (
        .clk         (clk),
        .reset       (reset),
        .load        (hb_load),
        .clear       (hb_clear),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_plus4),
        .instr       (hb_instr),
        .pc_plus4    (hb_pc_plus4),
        .full        (hb_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            IF_ID_Instr    <= NOP_INSTR;
            IF_ID_PC_Plus4 <= 32'h0;
            IF_ID_Valid    <= 1'b0;
        end else if (Branch_Taken) begin
            // A response landing this cycle belongs to the wrong path and is dropped.
            pc             <= word_align(Branch_Target);
            IF_ID_Instr    <= NOP_INSTR;
            IF_ID_PC_Plus4 <= 32'h0;
            IF_ID_Valid    <= 1'b0;
            state          <= (imem_req && !imem_ready) ? S_KILL : S_FETCH;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (fetch_load) begin
                        IF_ID_Instr    <= imem_rdata;
                        IF_ID_PC_Plus4 <= pc_plus4;
                        IF_ID_Valid    <= 1'b1;
                        pc             <= pc_plus4;
                    end else if (hb_load) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_unload) begin
                        IF_ID_Instr    <= hb_instr;
                        IF_ID_PC_Plus4 <= hb_pc_plus4;
                        IF_ID_Valid    <= 1'b1;
                        pc             <= pc_plus4;
                        state          <= S_FETCH;
                    end
                end
                S_KILL: begin
                    if (imem_ready) state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IF_STALL_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'h0;
            fetch_count  <= 32'h0;
        end else begin
            if (state != S_IDLE && !advance && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if ((fetch_load || hold_unload) && fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
